jtag_ir_scan_master: RTL and testbench
======================================

Name: jtag_ir_scan_master

Overview:
- Host-side JTAG driver for the TAP instruction register: generates TCK, TMS and TDI to load an instruction into a target IR.
- Samples TDO during the scan and returns the value the target captured in Capture-IR.
- Clocked by CLOCKIR, which acts as the master's system clock; TCK is derived from it by division.
- Also issues a TAP reset sequence (Test-Logic-Reset, then Run-Test-Idle). Used by on-chip test controllers and by the team's TAP verification benches.

Parameters:
- IR_WIDTH, 4, instruction register length in bits (min 2).
- CLK_DIV, 2, TCK half-period in CLOCKIR cycles (min 1).

Ports:
- CLOCKIR  in  1  master clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an IR scan of instr; sampled only in IDLE.
- tap_reset  in  1  request a TAP reset sequence; sampled only in IDLE; wins over start.
- instr  in  IR_WIDTH  instruction to shift, LSB first; latched when start is accepted.
- busy  out  1  high from acceptance until the sequence completes.
- done  out  1  one-cycle pulse when a scan or reset sequence ends.
- captured  out  IR_WIDTH  TDO bits sampled during Shift-IR, LSB = first bit out; valid from the done pulse.
- capture_ok  out  1  captured[1:0] == 2'b01 (IEEE 1149.1 mandatory capture bits); valid with captured.
- TCK  out  1  generated test clock.
- TMS  out  1  test mode select.
- TDI  out  1  test data to target.
- TDO  in  1  test data from target.

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, busy=0, done=0, captured=0, capture_ok=0, FSM=IDLE, counters=0. Reset is legal mid-sequence: all outputs return to reset values immediately; the partial scan is abandoned and captured is not updated.
- TCK cycle: a low phase of CLK_DIV CLOCKIR cycles, then a high phase of CLK_DIV cycles.
  - TMS/TDI change only at the start of the low phase (the TCK falling point).
  - TDO is sampled on the CLOCKIR edge that drives TCK high.
- States: IDLE, RST_SEQ, IR_SCAN, FINISH.
- IDLE:
  - TCK=0, TMS=1, TDI=0.
  - tap_reset=1 -> RST_SEQ, busy=1.
  - Else start=1 -> latch instr into shift register, IR_SCAN, busy=1.
  - start and tap_reset are ignored while busy.
- RST_SEQ: 6 TCK cycles, TMS = 1,1,1,1,1,0. The TAP ends in Run-Test-Idle. captured is unchanged.
- IR_SCAN:
  - Entry precondition: TAP is in Run-Test-Idle.
  - IR_WIDTH+6 TCK cycles, TMS = 1,1,0,0, then IR_WIDTH shift cycles (0 on all but the last, 1 on the last), then 1,0.
  - TAP path: Select-DR, Select-IR, Capture-IR, Shift-IR, shift, Exit1-IR, Update-IR, Run-Test-Idle.
  - TDI = instr bit i during shift cycle i (LSB first); TDI=0 outside shift cycles.
  - TDO sampled at the TCK rise of shift cycle i goes into captured bit i.
- FINISH: entered when the last TCK high phase ends (TCK returns to 0).
  - In the same cycle: done=1, busy=0, captured and capture_ok updated (IR_SCAN only), TMS=1 held.
  - Next cycle: IDLE, done=0.
- Latency: done is asserted 2*CLK_DIV*(IR_WIDTH+6) CLOCKIR cycles after the start-accept edge, or 2*CLK_DIV*6 cycles after the tap_reset-accept edge.
- Counters: the bit counter is sized to hold IR_WIDTH+6. The phase counter is sized for CLK_DIV. Neither wraps within a sequence.
- Back-to-back: start held high continuously gives a new scan accepted on the cycle after done; no gap cycles beyond that.

Test Plan:
- Reset: assert rst mid-IR_SCAN -> TCK=0, TMS=1, TDI=0, busy=0, done=0 within the same cycle; captured keeps its prior value.
- TAP reset, CLK_DIV=2: pulse tap_reset -> 6 TCK pulses with TMS 1,1,1,1,1,0; done exactly 24 cycles after acceptance; target TAP model in Run-Test-Idle.
- IR scan, target with capture pattern 4'b0101, instr=4'h7, CLK_DIV=1, IR_WIDTH=4:
  - Expect 10 TCK pulses and TMS 1,1,0,0,0,0,0,1,1,0.
  - TDI during shift = 1,1,1,0.
  - Target selected instruction = IDCODE.
  - captured=4'b0101, capture_ok=1, done at cycle 20.
- IR scan with target TDO stuck at 0, instr=4'hF -> captured=4'b0000, capture_ok=0; target selects BYPASS.
- Simultaneous start and tap_reset in IDLE -> reset sequence runs; instr is not latched.
- start asserted while busy -> ignored, no restart.
- Continuous start -> next scan accepted the cycle after done.

Source files
------------

// File: rtl/jtag_ir_scan_master.sv
// Host-side JTAG master: drives TCK/TMS/TDI to load a target's instruction register
// and returns the Capture-IR bits seen on TDO; also issues a TAP reset sequence.
module jtag_ir_scan_master #(
  parameter int IR_WIDTH = 4,
  parameter int CLK_DIV  = 2
) (
  input  logic                CLOCKIR,
  input  logic                rst,
  input  logic                start,
  input  logic                tap_reset,
  input  logic [IR_WIDTH-1:0] instr,
  output logic                busy,
  output logic                done,
  output logic [IR_WIDTH-1:0] captured,
  output logic                capture_ok,
  output logic                TCK,
  output logic                TMS,
  output logic                TDI,
  input  logic                TDO
);

  localparam int SCAN_LEN = IR_WIDTH + 6;
  localparam int BIT_W    = $clog2(SCAN_LEN + 1);
  localparam int PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // TCK-cycle indices within a sequence: 0..3 walk RTI -> Shift-IR, then the shift
  // cycles, then Exit1-IR -> Update-IR -> Run-Test-Idle.
  localparam logic [BIT_W-1:0] SHIFT_FIRST = BIT_W'(4);
  localparam logic [BIT_W-1:0] SHIFT_LAST  = BIT_W'(IR_WIDTH + 3);
  localparam logic [BIT_W-1:0] SHIFT_EXIT  = BIT_W'(IR_WIDTH + 4);
  localparam logic [BIT_W-1:0] SCAN_LAST   = BIT_W'(SCAN_LEN - 1);
  localparam logic [BIT_W-1:0] RST_LAST    = BIT_W'(5);
  localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RST_SEQ = 2'd1,
    IR_SCAN = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t              state_reg;
  logic [PH_W-1:0]     phase_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [IR_WIDTH-1:0] shift_reg;
  logic [IR_WIDTH-1:0] cap_reg;
  logic [IR_WIDTH-1:0] captured_reg;
  logic                capture_ok_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                tck_reg;
  logic                tms_reg;
  logic                tdi_reg;

  logic [BIT_W-1:0]    bit_next;
  logic                half_end;
  logic                shift_now;
  logic                shift_then;
  logic                last_bit;
  logic                tms_next;
  logic [IR_WIDTH-1:0] shift_next;

  always_comb begin
    bit_next   = bit_cnt_reg + 1'b1;
    half_end   = (phase_reg == PH_LAST);
    shift_now  = (state_reg == IR_SCAN) &&
                 (bit_cnt_reg >= SHIFT_FIRST) && (bit_cnt_reg <= SHIFT_LAST);
    shift_then = (state_reg == IR_SCAN) &&
                 (bit_next >= SHIFT_FIRST) && (bit_next <= SHIFT_LAST);
    last_bit   = (state_reg == RST_SEQ) ? (bit_cnt_reg == RST_LAST)
                                        : (bit_cnt_reg == SCAN_LAST);
    shift_next = shift_now ? (shift_reg >> 1) : shift_reg;
    tms_next   = 1'b1;
    if (state_reg == RST_SEQ) begin
      tms_next = (bit_next != RST_LAST);
    end else begin
      tms_next = (bit_next <= BIT_ONE) || (bit_next == SHIFT_LAST) ||
                 (bit_next == SHIFT_EXIT);
    end
  end

  always_ff @(posedge CLOCKIR or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      cap_reg        <= '0;
      captured_reg   <= '0;
      capture_ok_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      tck_reg        <= 1'b0;
      tms_reg        <= 1'b1;
      tdi_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tck_reg     <= 1'b0;
          tms_reg     <= 1'b1;
          tdi_reg     <= 1'b0;
          done_reg    <= 1'b0;
          phase_reg   <= '0;
          bit_cnt_reg <= '0;
          if (tap_reset) begin
            state_reg <= RST_SEQ;
            busy_reg  <= 1'b1;
          end else if (start) begin
            shift_reg <= instr;
            state_reg <= IR_SCAN;
            busy_reg  <= 1'b1;
          end
        end

        RST_SEQ, IR_SCAN: begin
          phase_reg <= half_end ? '0 : phase_reg + 1'b1;
          if (half_end) begin
            if (!tck_reg) begin
              // Rising TCK: the target's TDO has been stable since the falling point.
              tck_reg <= 1'b1;
              if (shift_now) begin
                cap_reg <= {TDO, cap_reg[IR_WIDTH-1:1]};
              end
            end else begin
              tck_reg <= 1'b0;
              if (last_bit) begin
                state_reg   <= FINISH;
                done_reg    <= 1'b1;
                busy_reg    <= 1'b0;
                tms_reg     <= 1'b1;
                tdi_reg     <= 1'b0;
                bit_cnt_reg <= '0;
                if (state_reg == IR_SCAN) begin
                  captured_reg   <= cap_reg;
                  capture_ok_reg <= (cap_reg[1:0] == 2'b01);
                end
              end else begin
                bit_cnt_reg <= bit_next;
                tms_reg     <= tms_next;
                tdi_reg     <= shift_then & shift_next[0];
                shift_reg   <= shift_next;
              end
            end
          end
        end

        FINISH: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          phase_reg <= '0;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign captured   = captured_reg;
  assign capture_ok = capture_ok_reg;
  assign TCK        = tck_reg;
  assign TMS        = tms_reg;
  assign TDI        = tdi_reg;

endmodule

// File: tb/tb_jtag_ir_scan_master.sv
// Bench for jtag_ir_scan_master: a behavioural TAP target on the JTAG pins, a table of
// IR scans with hand-computed results, and hand-written reset / busy / back-to-back cases.
module tb_jtag_ir_scan_master;

  localparam int IR_W     = 4;
  localparam int CLK_DIV  = 2;
  localparam int SCAN_N   = IR_W + 6;
  localparam int RST_N    = 6;
  localparam int SCAN_CYC = 2 * CLK_DIV * SCAN_N;
  localparam int RST_CYC  = 2 * CLK_DIV * RST_N;

  logic            CLOCKIR = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            tap_reset = 1'b0;
  logic [IR_W-1:0] instr = '0;
  logic            busy, done, capture_ok, TCK, TMS, TDI, TDO;
  logic [IR_W-1:0] captured;

  always #5 CLOCKIR = ~CLOCKIR;

  jtag_ir_scan_master #(.IR_WIDTH(IR_W), .CLK_DIV(CLK_DIV)) dut (
    .CLOCKIR(CLOCKIR), .rst(rst), .start(start), .tap_reset(tap_reset),
    .instr(instr), .busy(busy), .done(done), .captured(captured),
    .capture_ok(capture_ok), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  // ---------------- TAP target model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;

  tap_t            tap_st = TLR;
  logic [IR_W-1:0] tap_sr = '0;
  logic [IR_W-1:0] tap_ir = '1;
  logic [IR_W-1:0] cap_pat = '0;
  logic            tdo_r = 1'b0;
  logic            tdo_stuck0 = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    if (tap_st == CAP_IR) tap_sr <= cap_pat;
    else if (tap_st == SH_IR) tap_sr <= {TDI, tap_sr[IR_W-1:1]};
    tap_st <= tap_next(tap_st, TMS);
  end

  always @(negedge TCK) begin
    if (tap_st == SH_IR) tdo_r <= tap_sr[0];
    if (tap_st == UPD_IR) tap_ir <= tap_sr;
    if (tap_st == TLR) tap_ir <= '1;
  end

  assign TDO = tdo_stuck0 ? 1'b0 : tdo_r;

  // ---------------- pin monitor: logs TMS per TCK rise, TDI per shift ----------------
  logic tms_log [0:1023];
  logic tdi_log [0:1023];
  int   tck_total = 0, sh_total = 0, ones_total = 0;

  always @(posedge TCK) begin
    tms_log[tck_total % 1024] <= TMS;
    tck_total <= tck_total + 1;
    if (tap_st == SH_IR) begin
      tdi_log[sh_total % 1024] <= TDI;
      sh_total <= sh_total + 1;
    end
    if (TDI === 1'b1) ones_total <= ones_total + 1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_fail = 0;
  int base_tck, base_sh, base_ones;
  logic [31:0] exp_tms_scan, exp_tms_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_tms(input int base, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n && i < 32; i++) r[i] = tms_log[(base + i) % 1024];
    return r;
  endfunction

  function automatic logic [31:0] pack_tdi(input int base, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n && i < 32; i++) r[i] = tdi_log[(base + i) % 1024];
    return r;
  endfunction

  task automatic snapshot();
    base_tck  = tck_total;
    base_sh   = sh_total;
    base_ones = ones_total;
  endtask

  // Returns edges from the current cycle to the one where done is seen high.
  task automatic wait_done(output int lat);
    bit got = 1'b0;
    lat = -1;
    for (int i = 1; i <= 1000 && !got; i++) begin
      @(posedge CLOCKIR); #1;
      if (done === 1'b1) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_seq(input bit do_start, input bit do_rst, input logic [IR_W-1:0] ins);
    int lat;
    int exp_n;
    exp_n = do_rst ? RST_N : SCAN_N;
    snapshot();
    instr     = ins;
    start     = do_start;
    tap_reset = do_rst;
    @(posedge CLOCKIR); #1;
    start     = 1'b0;
    tap_reset = 1'b0;
    chk("busy_accept", busy, 1);
    wait_done(lat);
    chk("latency", lat, do_rst ? RST_CYC : SCAN_CYC);
    chk("tck_count", tck_total - base_tck, exp_n);
    chk("tms_seq", pack_tms(base_tck, exp_n), do_rst ? exp_tms_rst : exp_tms_scan);
    if (!do_rst) begin
      chk("shift_count", sh_total - base_sh, IR_W);
      chk("tdi_seq", pack_tdi(base_sh, IR_W), {{(32-IR_W){1'b0}}, ins});
    end else begin
      chk("tdi_quiet", ones_total - base_ones, 0);
    end
    chk("busy_at_done", busy, 0);
    chk("tck_at_done", TCK, 0);
    chk("tms_at_done", TMS, 1);
    @(posedge CLOCKIR); #1;
    chk("done_width", done, 0);
    chk("tap_in_rti", tap_st == RTI, 1);
    $display("seq %s instr=%h lat=%0d captured=%h capture_ok=%0d target_ir=%h",
             do_rst ? "tap_reset" : "ir_scan", ins, lat, captured, capture_ok, tap_ir);
  endtask

  typedef struct {
    logic [IR_W-1:0] instr;
    logic [IR_W-1:0] cap;
    bit              stuck0;
    logic [IR_W-1:0] exp_cap;
    bit              exp_ok;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat;
    exp_tms_scan = 32'h3 | (32'h1 << (IR_W + 3)) | (32'h1 << (IR_W + 4));
    exp_tms_rst  = 32'h1F;
    vecs[0] = '{instr: 4'h7, cap: 4'b0101, stuck0: 1'b0, exp_cap: 4'b0101, exp_ok: 1'b1};
    vecs[1] = '{instr: 4'hA, cap: 4'b0001, stuck0: 1'b0, exp_cap: 4'b0001, exp_ok: 1'b1};
    vecs[2] = '{instr: 4'h5, cap: 4'b1101, stuck0: 1'b0, exp_cap: 4'b1101, exp_ok: 1'b1};
    vecs[3] = '{instr: 4'h3, cap: 4'b0110, stuck0: 1'b0, exp_cap: 4'b0110, exp_ok: 1'b0};
    vecs[4] = '{instr: 4'hF, cap: 4'b0101, stuck0: 1'b1, exp_cap: 4'b0000, exp_ok: 1'b0};

    // Power-on reset
    repeat (3) @(posedge CLOCKIR);
    #1 rst = 1'b0;
    @(posedge CLOCKIR); #1;
    chk("rst_tck", TCK, 0);
    chk("rst_tms", TMS, 1);
    chk("rst_tdi", TDI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_captured", captured, 0);
    chk("rst_capture_ok", capture_ok, 0);

    // TAP reset brings the target from Test-Logic-Reset into Run-Test-Idle
    run_seq(1'b0, 1'b1, 4'h0);
    chk("tap_reset_captured", captured, 0);

    // Table of IR scans
    for (int v = 0; v < 5; v++) begin
      cap_pat    = vecs[v].cap;
      tdo_stuck0 = vecs[v].stuck0;
      run_seq(1'b1, 1'b0, vecs[v].instr);
      chk("captured", captured, vecs[v].exp_cap);
      chk("capture_ok", capture_ok, vecs[v].exp_ok);
      chk("target_ir", tap_ir, vecs[v].instr);
    end
    tdo_stuck0 = 1'b0;

    // Reset in the middle of a scan while TCK is high
    cap_pat = 4'b1101;
    snapshot();
    instr = 4'h6;
    start = 1'b1;
    @(posedge CLOCKIR); #1;
    start = 1'b0;
    repeat (15) @(posedge CLOCKIR);
    #2;
    chk("mid_tck_high", TCK, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tck", TCK, 0);
    chk("mid_rst_tms", TMS, 1);
    chk("mid_rst_tdi", TDI, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_captured", captured, 0);
    @(posedge CLOCKIR); #1;
    rst = 1'b0;
    repeat (3) @(posedge CLOCKIR);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    $display("seq mid_scan_reset captured=%h busy=%0d", captured, busy);
    run_seq(1'b0, 1'b1, 4'h0);

    // IDCODE scan to leave a non-zero captured value behind
    cap_pat = 4'b0101;
    run_seq(1'b1, 1'b0, 4'h7);
    chk("idcode_captured", captured, 4'b0101);
    chk("idcode_ir", tap_ir, 4'h7);

    // start and tap_reset together: reset wins, instr never reaches TDI
    run_seq(1'b1, 1'b1, 4'hF);
    chk("both_captured_kept", captured, 4'b0101);
    chk("both_capture_ok_kept", capture_ok, 1);

    // start / tap_reset pulsed while busy are ignored
    cap_pat = 4'b0001;
    snapshot();
    instr = 4'hA;
    start = 1'b1;
    @(posedge CLOCKIR); #1;
    start = 1'b0;
    repeat (5) @(posedge CLOCKIR);
    #1;
    instr     = 4'h5;
    start     = 1'b1;
    tap_reset = 1'b1;
    @(posedge CLOCKIR); #1;
    start     = 1'b0;
    tap_reset = 1'b0;
    chk("busy_hold", busy, 1);
    wait_done(lat);
    chk("busy_ign_latency", lat + 6, SCAN_CYC);
    chk("busy_ign_tck", tck_total - base_tck, SCAN_N);
    chk("busy_ign_ir", tap_ir, 4'hA);
    chk("busy_ign_captured", captured, 4'b0001);
    repeat (4) @(posedge CLOCKIR);
    #1;
    chk("busy_ign_idle", busy, 0);
    $display("seq busy_ignore lat=%0d target_ir=%h", lat + 6, tap_ir);

    // Continuous start: next accept lands on the cycle after done
    cap_pat = 4'b0101;
    instr   = 4'h7;
    start   = 1'b1;
    @(posedge CLOCKIR); #1;
    wait_done(lat);
    chk("b2b_first_latency", lat, SCAN_CYC);
    @(posedge CLOCKIR); #1;
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_gap_done", done, 0);
    @(posedge CLOCKIR); #1;
    chk("b2b_accept", busy, 1);
    start = 1'b0;
    instr = 4'h3;
    wait_done(lat);
    chk("b2b_second_latency", lat, SCAN_CYC);
    chk("b2b_captured", captured, 4'b0101);
    chk("b2b_ir", tap_ir, 4'h7);
    $display("seq back_to_back lat=%0d captured=%h", lat, captured);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

endmodule
